// File: rtl/rtc_bus_sequencer.sv
// Burst sequencer for the RTC multiplexed address/data bus.
// Ports: start/mode/base_addr/count in; strobes, bus_out/oe, rd_data, busy/done out.
module rtc_bus_sequencer #(
  parameter int DW      = 8,
  parameter int NUM_W   = 5,
  parameter int T_PHASE = 4,
  parameter int T_GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    base_addr,
  input  logic [NUM_W-1:0] count,
  input  logic [DW-1:0]    wr_data,
  input  logic [DW-1:0]    bus_in,
  output logic [NUM_W-1:0] reg_idx,
  output logic [DW-1:0]    bus_out,
  output logic             bus_oe,
  output logic             AD,
  output logic             CS,
  output logic             RD,
  output logic             WR,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done
);

  localparam int TMAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] PH_LD  = CW'(T_PHASE - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASETUP,
    S_ASTROBE,
    S_AHOLD,
    S_DSETUP,
    S_DSTROBE,
    S_DHOLD,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_base;
  logic [NUM_W-1:0] r_count;
  logic             r_rd;
  logic             r_wr;

  logic [NUM_W-1:0] w_idx_nxt;
  logic [DW-1:0]    w_addr_nxt;
  logic             w_last;

  assign w_idx_nxt  = reg_idx + NUM_W'(1);
  assign w_addr_nxt = r_base + DW'(w_idx_nxt);
  assign w_last     = (reg_idx == r_count - NUM_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_base   <= '0;
      r_count  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      reg_idx  <= '0;
      bus_out  <= '0;
      bus_oe   <= 1'b0;
      AD       <= 1'b1;
      CS       <= 1'b1;
      RD       <= 1'b1;
      WR       <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_base  <= base_addr;
          r_count <= count;
          r_rd    <= (mode == 2'b01);
          r_wr    <= (mode == 2'b00);
          if (count == '0) begin
            done <= 1'b1;
          end else begin
            busy    <= 1'b1;
            reg_idx <= '0;
            r_state <= S_ASETUP;
            r_cnt   <= PH_LD;
            CS      <= 1'b0;
            AD      <= 1'b0;
            bus_oe  <= 1'b1;
            bus_out <= base_addr;
          end
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_cnt <= PH_LD;
        unique case (r_state)
          S_ASETUP: begin
            r_state <= S_ASTROBE;
            WR      <= 1'b0;
          end
          S_ASTROBE: begin
            r_state <= S_AHOLD;
            WR      <= 1'b1;
          end
          S_AHOLD: begin
            r_state <= S_DSETUP;
            AD      <= 1'b1;
            bus_oe  <= !r_rd;
            // clear and reserved modes both drive zeros
            if (!r_rd) bus_out <= r_wr ? wr_data : '0;
          end
          S_DSETUP: begin
            r_state <= S_DSTROBE;
            if (r_rd) RD <= 1'b0;
            else      WR <= 1'b0;
          end
          S_DSTROBE: begin
            r_state <= S_DHOLD;
            RD      <= 1'b1;
            WR      <= 1'b1;
            if (r_rd) begin
              rd_data  <= bus_in;
              rd_valid <= 1'b1;
            end
          end
          S_DHOLD: begin
            r_state <= S_GAP;
            r_cnt   <= GAP_LD;
            CS      <= 1'b1;
            AD      <= 1'b1;
            bus_oe  <= 1'b0;
          end
          S_GAP: begin
            if (w_last) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state <= S_ASETUP;
              reg_idx <= w_idx_nxt;
              CS      <= 1'b0;
              AD      <= 1'b0;
              bus_oe  <= 1'b1;
              bus_out <= w_addr_nxt;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer.
// One task per scenario; strobe protocol watched continuously.
module tb_rtc_bus_sequencer;

  localparam int L = 26;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] base_addr;
  logic [4:0] count;
  logic [7:0] wr_data;
  logic [7:0] bus_in;
  logic [4:0] reg_idx;
  logic [7:0] bus_out;
  logic       bus_oe, AD, CS, RD, WR;
  logic [7:0] rd_data;
  logic       rd_valid, busy, done;

  int tests = 0;
  int fails = 0;
  int prot_err = 0;

  logic [7:0] rd_model [4];
  logic [7:0] addr_q[$], data_q[$], rdv_q[$];
  logic [4:0] rdi_q[$];
  int wrun_q[$], rrun_q[$];
  int busy_cyc, busy_first, busy_last, done_n, done_cyc, act;

  rtc_bus_sequencer #(.DW(8), .NUM_W(5), .T_PHASE(4), .T_GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .base_addr(base_addr), .count(count), .wr_data(wr_data),
    .bus_in(bus_in), .reg_idx(reg_idx), .bus_out(bus_out),
    .bus_oe(bus_oe), .AD(AD), .CS(CS), .RD(RD), .WR(WR),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign wr_data = 8'h10 + {3'b000, reg_idx};
  assign bus_in  = rd_model[reg_idx[1:0]];

  logic       p_low = 1'b0;
  logic [7:0] p_bus = '0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (!WR && !RD) prot_err++;
      if ((!WR || !RD) && CS) prot_err++;
      if (!RD && bus_oe) prot_err++;
      if ((!WR || !RD) && p_low && bus_out !== p_bus) prot_err++;
    end
    p_low = (!WR || !RD);
    p_bus = bus_out;
  end

  task automatic run_burst(input logic [1:0] m, input logic [7:0] b,
                           input logic [4:0] n, input int extra);
    logic pw, pr;
    int wrun, rrun;
    addr_q.delete(); data_q.delete(); rdv_q.delete(); rdi_q.delete();
    wrun_q.delete(); rrun_q.delete();
    busy_cyc = 0; busy_first = -1; busy_last = -1;
    done_n = 0; done_cyc = -1; act = 0;
    pw = 1'b1; pr = 1'b1; wrun = 0; rrun = 0;
    @(negedge clk);
    mode = m; base_addr = b; count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (busy) begin
        busy_cyc++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done) begin done_n++; done_cyc = c; end
      if (!CS || !AD || !WR || !RD || bus_oe) act++;
      if (!WR && pw) begin
        if (!AD) addr_q.push_back(bus_out);
        else     data_q.push_back(bus_out);
      end
      if (!WR) wrun++;
      else if (!pw) begin wrun_q.push_back(wrun); wrun = 0; end
      if (!RD) rrun++;
      else if (!pr) begin rrun_q.push_back(rrun); rrun = 0; end
      if (rd_valid) begin
        rdv_q.push_back(rd_data);
        rdi_q.push_back(reg_idx);
      end
      pw = WR; pr = RD;
      if (done_n > 0 && c >= done_cyc + 2) break;
      start = (c == extra);
      if (c == extra) begin count = 5'd7; base_addr = 8'h55; end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; mode = 2'b00; base_addr = '0; count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({AD, CS, RD, WR, bus_oe, busy, done, rd_valid} !== 8'b11110000) begin
      fails++;
      $display("FAIL reset_ctl got %b want 11110000",
               {AD, CS, RD, WR, bus_oe, busy, done, rd_valid});
    end
    tests++;
    if ({bus_out, rd_data, reg_idx} !== 21'd0) begin
      fails++;
      $display("FAIL reset_data got %h/%h/%h want 0", bus_out, rd_data, reg_idx);
    end
    rst = 1'b1;
  endtask

  task automatic test_reset_mid;
    int dn;
    @(negedge clk);
    mode = 2'b00; base_addr = 8'h40; count = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !(!WR && AD); i++) @(negedge clk);
    tests++;
    if (!(!WR && AD)) begin
      fails++;
      $display("FAIL mid_reach got WR=%b AD=%b want data strobe", WR, AD);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({AD, CS, RD, WR, bus_oe, busy} !== 6'b111100) begin
      fails++;
      $display("FAIL mid_async got %b want 111100", {AD, CS, RD, WR, bus_oe, busy});
    end
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done) dn++;
    tests++;
    if (dn !== 0) begin
      fails++;
      $display("FAIL mid_nodone got %0d pulses want 0", dn);
    end
    run_burst(2'b00, 8'h40, 5'd1, -1);
    tests++;
    if (addr_q.size() != 1 || addr_q[0] !== 8'h40 ||
        data_q.size() != 1 || data_q[0] !== 8'h10) begin
      fails++;
      $display("FAIL mid_clean got %0d addr %0d data want 1 burst 40/10",
               addr_q.size(), data_q.size());
    end
    tests++;
    if (done_n != 1 || done_cyc != L + 1) begin
      fails++;
      $display("FAIL mid_done got n=%0d cyc=%0d want 1/%0d", done_n, done_cyc, L + 1);
    end
  endtask

  task automatic test_write;
    run_burst(2'b00, 8'h21, 5'd3, -1);
    tests++;
    if (addr_q.size() != 3 || data_q.size() != 3) begin
      fails++;
      $display("FAIL wr_len got %0d/%0d want 3/3", addr_q.size(), data_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (addr_q[i] !== 8'h21 + 8'(i) || data_q[i] !== 8'h10 + 8'(i)) begin
          fails++;
          $display("FAIL wr_reg%0d got %h/%h want %h/%h", i, addr_q[i], data_q[i],
                   8'h21 + 8'(i), 8'h10 + 8'(i));
        end
      end
    end
    tests++;
    if (wrun_q.size() != 6) begin
      fails++;
      $display("FAIL wr_runs got %0d want 6", wrun_q.size());
    end else begin
      foreach (wrun_q[i]) begin
        tests++;
        if (wrun_q[i] != 4) begin
          fails++;
          $display("FAIL wr_width%0d got %0d want 4", i, wrun_q[i]);
        end
      end
    end
    tests++;
    if (busy_cyc != 78 || busy_first != 1 || busy_last != 78) begin
      fails++;
      $display("FAIL wr_busy got %0d (%0d..%0d) want 78 (1..78)",
               busy_cyc, busy_first, busy_last);
    end
    tests++;
    if (done_n != 1 || done_cyc != 79) begin
      fails++;
      $display("FAIL wr_done got n=%0d cyc=%0d want 1/79", done_n, done_cyc);
    end
  endtask

  task automatic test_read;
    rd_model[0] = 8'hA5; rd_model[1] = 8'h3C;
    run_burst(2'b01, 8'h28, 5'd2, -1);
    tests++;
    if (rdv_q.size() != 2) begin
      fails++;
      $display("FAIL rd_valid_n got %0d want 2", rdv_q.size());
    end else begin
      tests++;
      if (rdv_q[0] !== 8'hA5 || rdv_q[1] !== 8'h3C) begin
        fails++;
        $display("FAIL rd_data got %h,%h want a5,3c", rdv_q[0], rdv_q[1]);
      end
      tests++;
      if (rdi_q[0] !== 5'd0 || rdi_q[1] !== 5'd1) begin
        fails++;
        $display("FAIL rd_idx got %0d,%0d want 0,1", rdi_q[0], rdi_q[1]);
      end
    end
    tests++;
    if (addr_q.size() != 2 || addr_q[0] !== 8'h28 || addr_q[1] !== 8'h29) begin
      fails++;
      $display("FAIL rd_addr got %0d entries want 28,29", addr_q.size());
    end
    tests++;
    if (data_q.size() != 0 || wrun_q.size() != 2) begin
      fails++;
      $display("FAIL rd_nowr got %0d data WR, %0d WR runs want 0/2",
               data_q.size(), wrun_q.size());
    end
    tests++;
    if (rrun_q.size() != 2 || rrun_q[0] != 4 || rrun_q[1] != 4) begin
      fails++;
      $display("FAIL rd_strobe got %0d RD runs want 2 of 4", rrun_q.size());
    end
    tests++;
    if (done_n != 1 || done_cyc != 2 * L + 1) begin
      fails++;
      $display("FAIL rd_done got n=%0d cyc=%0d want 1/%0d", done_n, done_cyc, 2 * L + 1);
    end
  endtask

  task automatic test_clear_wrap;
    run_burst(2'b10, 8'hFE, 5'd3, -1);
    tests++;
    if (addr_q.size() != 3 || data_q.size() != 3) begin
      fails++;
      $display("FAIL clr_len got %0d/%0d want 3/3", addr_q.size(), data_q.size());
    end else begin
      tests++;
      if (addr_q[0] !== 8'hFE || addr_q[1] !== 8'hFF || addr_q[2] !== 8'h00) begin
        fails++;
        $display("FAIL clr_addr got %h,%h,%h want fe,ff,00",
                 addr_q[0], addr_q[1], addr_q[2]);
      end
      tests++;
      if (data_q[0] !== 8'h00 || data_q[1] !== 8'h00 || data_q[2] !== 8'h00) begin
        fails++;
        $display("FAIL clr_data got %h,%h,%h want 00", data_q[0], data_q[1], data_q[2]);
      end
    end
    tests++;
    if (done_n != 1 || done_cyc != 79) begin
      fails++;
      $display("FAIL clr_done got n=%0d cyc=%0d want 1/79", done_n, done_cyc);
    end
  endtask

  task automatic test_count0_and_restart;
    run_burst(2'b00, 8'h30, 5'd0, -1);
    tests++;
    if (done_n != 1 || done_cyc != 1 || busy_cyc != 0 || act != 0) begin
      fails++;
      $display("FAIL cnt0 got done=%0d@%0d busy=%0d act=%0d want 1@1 0 0",
               done_n, done_cyc, busy_cyc, act);
    end
    run_burst(2'b00, 8'h21, 5'd3, 30);
    tests++;
    if (addr_q.size() != 3 || busy_cyc != 78 || done_n != 1 || done_cyc != 79) begin
      fails++;
      $display("FAIL restart got regs=%0d busy=%0d done=%0d@%0d want 3 78 1@79",
               addr_q.size(), busy_cyc, done_n, done_cyc);
    end
    tests++;
    if (addr_q.size() == 3 && addr_q[2] !== 8'h23) begin
      fails++;
      $display("FAIL restart_addr got %h want 23", addr_q[2]);
    end
  endtask

  task automatic test_random;
    logic [1:0] m;
    logic [7:0] b, ed;
    logic [4:0] n;
    for (int k = 0; k < 4; k++) begin
      m = 2'($urandom_range(0, 3));
      b = 8'($urandom);
      n = 5'($urandom_range(1, 3));
      rd_model[0] = 8'($urandom); rd_model[1] = 8'($urandom);
      rd_model[2] = 8'($urandom);
      run_burst(m, b, n, -1);
      tests++;
      if (done_n != 1 || busy_cyc != int'(n) * L) begin
        fails++;
        $display("FAIL rnd%0d_len got done=%0d busy=%0d want 1/%0d",
                 k, done_n, busy_cyc, int'(n) * L);
      end
      tests++;
      if (addr_q.size() != int'(n)) begin
        fails++;
        $display("FAIL rnd%0d_regs got %0d want %0d", k, addr_q.size(), n);
      end else begin
        for (int i = 0; i < int'(n); i++) begin
          ed = (m == 2'b00) ? 8'h10 + 8'(i) : 8'h00;
          tests++;
          if (addr_q[i] !== b + 8'(i)) begin
            fails++;
            $display("FAIL rnd%0d_addr%0d got %h want %h", k, i, addr_q[i], b + 8'(i));
          end
          if (m == 2'b01) begin
            tests++;
            if (rdv_q.size() != int'(n) || rdv_q[i] !== rd_model[i]) begin
              fails++;
              $display("FAIL rnd%0d_rd%0d want %h", k, i, rd_model[i]);
            end
          end else begin
            tests++;
            if (data_q.size() != int'(n) || data_q[i] !== ed) begin
              fails++;
              $display("FAIL rnd%0d_data%0d want %h", k, i, ed);
            end
          end
        end
      end
    end
    tests++;
    if (prot_err != 0) begin
      fails++;
      $display("FAIL protocol got %0d violations want 0", prot_err);
    end
  endtask

  initial begin
    rd_model[0] = '0; rd_model[1] = '0; rd_model[2] = '0; rd_model[3] = '0;
    test_reset();
    test_write();
    test_read();
    test_clear_wrap();
    test_count0_and_restart();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
